result_trace_buffer: RTL and testbench
======================================

RESULT_TRACE_BUFFER -- requirements
Module: result_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; power of two, 2..256.
REQ-002 Parameter CYCLE_W, default 16, timestamp width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 result  input  32  processor result bus, sampled every cycle.
REQ-006 capture_en  input  1  1 = change detection and capture enabled.
REQ-007 out_ready  input  1  consumer accepts the head entry.
REQ-008 out_valid  output  1  head entry present.
REQ-009 out_data  output  32  head entry's captured result value.
REQ-010 out_cycle  output  CYCLE_W  head entry's cycle timestamp.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 overflow  output  1  sticky; at least one capture was dropped.
REQ-013 drop_cnt  output  8  dropped captures, saturating at 255.

Function
REQ-014 Free-running cycle counter: +1 every cycle after reset; wraps from 2^CYCLE_W-1 to 0.
REQ-015 prev register: loads result every cycle regardless of capture_en.
REQ-016 Capture request when capture_en=1 and result != prev.
REQ-017 Captured entry = {cycle counter value in the same cycle, result}; entry is visible at the output one cycle later (latency 1).
REQ-018 Pop when out_valid=1 and out_ready=1; head advances at that edge.
REQ-019 out_data and out_cycle are stable while out_valid=1 and out_ready=0.
REQ-020 Full (count=DEPTH) with capture and no pop: entry dropped, overflow set, drop_cnt incremented (saturating).
REQ-021 Full with capture and pop in the same cycle: both occur, nothing dropped, count unchanged.
REQ-022 Empty with capture: pop is impossible (out_valid=0); entry is written and count becomes 1.
REQ-023 Non-full capture and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-024 Read and write pointers wrap modulo DEPTH.
REQ-025 Changes occurring while capture_en=0 are not recorded; after re-enable, only subsequent changes relative to prev are captured.
REQ-026 overflow and drop_cnt clear only on rst.

Reset
REQ-027 rst=1 at a clock edge: pointers=0, count=0, out_valid=0, out_data=0, out_cycle=0, overflow=0, drop_cnt=0, cycle counter=0, prev=0.
REQ-028 rst asserted mid-operation discards all stored entries and any capture in that cycle; no partial state survives.
REQ-029 After rst is released, a first result value that is nonzero is captured as a change from prev=0.

Structure
REQ-030 Shared package trace_pkg holds the RESULT_W=32 constant, the default CYCLE_W, and the trace entry struct {cycle, data}.
REQ-031 Storage lives in one sub-module, trace_fifo (synchronous FIFO with push/pop/full/empty/count); the top holds change detection, timestamping, and overflow accounting.
REQ-032 No combinational path from out_ready to out_valid, out_data, or out_cycle.

Verification
REQ-033 Reset, then result 0 -> 5 at cycle 3 with capture_en=1 and out_ready=1 -> one entry {cycle=3, data=5}; out_valid for exactly 1 cycle.
REQ-034 result held constant at 7 for 20 cycles -> at most one capture (the initial change); count never exceeds 1.
REQ-035 out_ready=0, 20 distinct consecutive values, DEPTH=16 -> count=16, overflow=1, drop_cnt=4; the drained order is the first 16 values.
REQ-036 FIFO full, then a new value with out_ready=1 in the same cycle -> count remains 16, drop_cnt unchanged.
REQ-037 3 entries stored, rst pulsed for 1 cycle -> count=0, out_valid=0, overflow=0, cycle counter restarts at 0.
REQ-038 capture_en=0 while result changes 1 -> 2 -> 3, then re-enable, then result 4 -> exactly one entry {data=4}.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the result trace buffer.
//   RESULT_W    : width of the processor result bus.
//   CYCLE_W_DEF : default timestamp width.
//   trace_entry_t : one captured entry {cycle, data} at the default widths.
//                   The FIFO stores the same layout as a flat vector
//                   {cycle, data}, so the struct also describes its bit order.
package trace_pkg;

  localparam int RESULT_W    = 32;
  localparam int CYCLE_W_DEF = 16;

  typedef struct packed {
    logic [CYCLE_W_DEF-1:0] cycle;
    logic [RESULT_W-1:0]    data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding captured trace entries.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (pointers, count).
//   push       : write wr_data at the tail; ignored when full unless popping.
//   wr_data    : entry to store.
//   pop        : advance the head; ignored when empty.
//   rd_data    : head entry, forced to zero while empty.
//   full/empty : occupancy flags derived from the registered count.
//   count      : number of stored entries (0..DEPTH).
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO is legal only when the head leaves in the same
  // cycle; the write then lands in the slot the head is vacating.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is read straight from storage: it only changes on a pop edge, so it
  // stays stable while the consumer stalls and has no path from pop.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; stale contents are unreachable after reset
  // because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/result_trace_buffer.sv
// Result trace buffer: watches a processor result bus, timestamps every
// change while capture is enabled and queues it for a consumer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset.
//   result      : result bus, sampled every cycle.
//   capture_en  : enables change detection and capture.
//   out_ready   : consumer accepts the head entry.
//   out_valid   : head entry present.
//   out_data    : head entry result value.
//   out_cycle   : head entry timestamp.
//   count       : stored entries.
//   overflow    : sticky, set when a capture was dropped on a full buffer.
//   drop_cnt    : dropped captures, saturating at 255.
module result_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = CYCLE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RESULT_W-1:0]     result,
  input  logic                    capture_en,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [RESULT_W-1:0]     out_data,
  output logic [CYCLE_W-1:0]      out_cycle,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int ENTRY_W = CYCLE_W + RESULT_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [CYCLE_W-1:0]  cyc_q, cyc_d;
  logic [RESULT_W-1:0] prev_q, prev_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic                capture_req;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;

  // prev tracks the bus unconditionally, so re-enabling capture only sees
  // changes relative to the value present just before re-enable.
  assign capture_req = capture_en && (result != prev_q);
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  // Full implies out_valid, so a ready consumer always makes room.
  assign drop        = capture_req && fifo_full && !pop;
  assign wr_entry    = {cyc_q, result};

  always_comb begin
    cyc_d      = cyc_q + CYCLE_W'(1);
    prev_d     = result;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture_req),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign out_cycle = rd_entry[ENTRY_W-1:RESULT_W];
  assign out_data  = rd_entry[RESULT_W-1:0];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_result_trace_buffer.sv
module tb_result_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH   = 16;
  localparam int CYCLE_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [RESULT_W-1:0]     result;
  logic                    capture_en;
  logic                    out_ready;
  logic                    out_valid;
  logic [RESULT_W-1:0]     out_data;
  logic [CYCLE_W-1:0]      out_cycle;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [7:0]              drop_cnt;

  int total = 0;
  int bad   = 0;

  result_trace_buffer #(
    .DEPTH   (DEPTH),
    .CYCLE_W (CYCLE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .result     (result),
    .capture_en (capture_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_cycle  (out_cycle),
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse; rval is on the bus during the reset edge.
  task automatic pulse_reset(input logic [31:0] rval);
    rst    = 1'b1;
    result = rval;
    step();
    rst    = 1'b0;
    result = '0;
  endtask

  trace_entry_t exp_e;

  initial begin
    rst = 1'b1; result = '0; capture_en = 1'b1; out_ready = 1'b1;
    step();
    pulse_reset(32'd0);

    // Reset state
    chk("rst_count",    count,     0);
    chk("rst_valid",    out_valid, 0);
    chk("rst_data",     out_data,  0);
    chk("rst_cycle",    out_cycle, 0);
    chk("rst_overflow", overflow,  0);
    chk("rst_drop",     drop_cnt,  0);

    // Single change 0 -> 5 at cycle 3, consumer ready
    step(); step(); step();
    result = 32'd5;
    step();
    exp_e = '{cycle: 16'd3, data: 32'd5};
    chk("one_valid", out_valid, 1);
    chk("one_data",  out_data,  exp_e.data);
    chk("one_cycle", out_cycle, exp_e.cycle);
    chk("one_count", count,     1);
    step();
    chk("one_valid_gone", out_valid, 0);
    chk("one_count_gone", count,     0);

    // Constant 7 for 20 cycles: only the first change from prev=0 at cycle 0
    pulse_reset(32'd0);
    out_ready = 1'b0;
    result    = 32'd7;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_count", count, 1);
    end
    chk("hold_data",  out_data,  7);
    chk("hold_cycle", out_cycle, 0);

    // Push and pop together on a non-full FIFO: count stays 1, order kept
    pulse_reset(32'd0);
    out_ready = 1'b1;
    result    = 32'd10;
    step();
    for (int i = 1; i <= 3; i++) begin
      result = 32'd10 + i;
      step();
      chk("pp_count", count,     1);
      chk("pp_data",  out_data,  10 + i);
      chk("pp_cycle", out_cycle, i);
    end

    // 20 distinct values with consumer stalled: 16 kept, 4 dropped
    pulse_reset(32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      result = 32'd100 + i;
      step();
      chk("fill_head_stable", out_data, 100);
    end
    chk("fill_count",    count,     16);
    chk("fill_overflow", overflow,  1);
    chk("fill_drop",     drop_cnt,  4);
    chk("fill_cycle",    out_cycle, 0);

    // Full + capture + pop in the same cycle (bus at cycle 20)
    result    = 32'd200;
    out_ready = 1'b1;
    step();
    chk("fullpp_count", count,    16);
    chk("fullpp_drop",  drop_cnt, 4);

    // Drain: first 16 values minus the popped head, then the new entry
    for (int i = 0; i < 16; i++) begin
      chk("drain_data",  out_data,  (i < 15) ? (101 + i) : 200);
      chk("drain_cycle", out_cycle, (i < 15) ? (1 + i)   : 20);
      step();
    end
    chk("drain_valid",    out_valid, 0);
    chk("drain_count",    count,     0);
    chk("drain_overflow", overflow,  1);

    // 3 entries then reset, with a differing value on the bus during reset
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      result = i;
      step();
    end
    chk("pre_rst_count", count, 3);
    pulse_reset(32'd55);
    chk("mid_rst_count",    count,     0);
    chk("mid_rst_valid",    out_valid, 0);
    chk("mid_rst_overflow", overflow,  0);
    chk("mid_rst_drop",     drop_cnt,  0);
    result = 32'd9;
    step();
    chk("post_rst_count", count,     1);
    chk("post_rst_data",  out_data,  9);
    chk("post_rst_cycle", out_cycle, 0);

    // Changes while disabled are ignored; re-enable then 4 at cycle 4
    pulse_reset(32'd0);
    capture_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      result = i;
      step();
      chk("dis_count", count, 0);
    end
    capture_en = 1'b1;
    step();
    chk("reen_count", count, 0);
    result = 32'd4;
    step();
    step();
    chk("reen_count1", count,     1);
    chk("reen_data",   out_data,  4);
    chk("reen_cycle",  out_cycle, 4);

    // Drop counter saturates at 255
    pulse_reset(32'd0);
    for (int i = 0; i < 300; i++) begin
      result = 32'd1000 + i;
      step();
    end
    chk("sat_drop",     drop_cnt, 255);
    chk("sat_overflow", overflow, 1);
    chk("sat_count",    count,    16);
    chk("sat_head",     out_data, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
